// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the Gray sequence controller.
// bin2gray is the reference conversion used by verification models.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray converter.
module bin_to_gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_sequence_controller.sv
// Steps a binary counter from a command and streams its Gray codes with a last marker and done pulse.
// Optional macro GRAY_DOWN_EN enables down-counting via cmd_down; otherwise the counter only increments.
module gray_sequence_controller
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_len,
  input  logic             cmd_down,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] bin_step;

`ifdef GRAY_DOWN_EN
  logic dir_q, dir_d;

  assign bin_step = dir_q ? (bin_q - ONE) : (bin_q + ONE);
`else
  logic unused_cmd_down;

  assign unused_cmd_down = cmd_down;
  assign bin_step        = bin_q + ONE;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    rem_d   = rem_q;
`ifdef GRAY_DOWN_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          bin_d   = cmd_start;
          rem_d   = cmd_len;
`ifdef GRAY_DOWN_EN
          dir_d   = cmd_down;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        // Counter and remaining length only move on an accepted beat.
        if (out_ready) begin
          if (rem_q == ZERO) begin
            state_d = DONE;
          end else begin
            bin_d = bin_step;
            rem_d = rem_q - ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      rem_q   <= '0;
`ifdef GRAY_DOWN_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      rem_q   <= rem_d;
`ifdef GRAY_DOWN_EN
      dir_q   <= dir_d;
`endif
    end
  end

  bin_to_gray #(
    .WIDTH(WIDTH)
  ) u_bin_to_gray (
    .bin  (bin_q),
    .gray (out_gray)
  );

  // All outputs decode from registered state only.
  assign cmd_ready = (state_q == IDLE);
  assign out_valid = (state_q == RUN);
  assign out_last  = (state_q == RUN) && (rem_q == ZERO);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_gray_sequence_controller.sv
// Directed bench for gray_sequence_controller with hand-computed Gray sequences.
module tb_gray_sequence_controller;

  localparam int WIDTH = 4;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_len;
  logic             cmd_down;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gray;
  logic             out_last;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  int hs     = 0;

  gray_sequence_controller #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_len   (cmd_len),
    .cmd_down  (cmd_down),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input string tag, input logic [3:0] g, input logic last);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_gray"}, 32'(out_gray), 32'(g));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    if (out_valid && out_ready) hs++;
    step();
  endtask

  task automatic issue(input string tag, input logic [3:0] s, input logic [3:0] l, input logic d);
    cmd_start = s;
    cmd_len   = l;
    cmd_down  = d;
    cmd_valid = 1'b1;
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_seq(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_cmd_ready"}, 32'(cmd_ready), 32'd0);
    step();
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_start = '0;
    cmd_len   = '0;
    cmd_down  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gray", 32'(out_gray), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Up count: bins 0,1,2,3
    out_ready = 1'b1;
    issue("up", 4'd0, 4'd3, 1'b0);
    chk("up_busy", 32'(busy), 32'd1);
    beat("up0", 4'd0, 1'b0);
    beat("up1", 4'd1, 1'b0);
    beat("up2", 4'd3, 1'b0);
    beat("up3", 4'd2, 1'b1);
    finish_seq("up");

    // Up wrap: bins 14,15,0,1
    issue("wrap", 4'd14, 4'd3, 1'b0);
    beat("wrap0", 4'd9, 1'b0);
    beat("wrap1", 4'd8, 1'b0);
    beat("wrap2", 4'd0, 1'b0);
    beat("wrap3", 4'd1, 1'b1);
    finish_seq("wrap");

    // Down request: bins 1,0,15 when enabled, else 1,2,3
    issue("down", 4'd1, 4'd2, 1'b1);
    beat("down0", 4'd1, 1'b0);
`ifdef GRAY_DOWN_EN
    beat("down1", 4'd0, 1'b0);
    beat("down2", 4'd8, 1'b1);
`else
    beat("down1", 4'd3, 1'b0);
    beat("down2", 4'd2, 1'b1);
`endif
    finish_seq("down");

    // Backpressure: bins 5,6,7 with ready pattern 0,0,1,0,1,1
    out_ready = 1'b0;
    issue("bp", 4'd5, 4'd2, 1'b0);
    hs = 0;
    out_ready = 1'b0; beat("bp_c1", 4'd7, 1'b0);
    out_ready = 1'b0; beat("bp_c2", 4'd7, 1'b0);
    out_ready = 1'b1; beat("bp_c3", 4'd7, 1'b0);
    out_ready = 1'b0; beat("bp_c4", 4'd5, 1'b0);
    out_ready = 1'b1; beat("bp_c5", 4'd5, 1'b0);
    out_ready = 1'b1; beat("bp_c6", 4'd4, 1'b1);
    chk("bp_handshakes", 32'(hs), 32'd3);
    finish_seq("bp");

    // Second command held during RUN must be ignored
    issue("busycmd", 4'd0, 4'd3, 1'b0);
    cmd_start = 4'd10;
    cmd_len   = 4'd0;
    cmd_valid = 1'b1;
    beat("busycmd0", 4'd0, 1'b0);
    beat("busycmd1", 4'd1, 1'b0);
    beat("busycmd2", 4'd3, 1'b0);
    cmd_valid = 1'b0;
    beat("busycmd3", 4'd2, 1'b1);
    finish_seq("busycmd");

    // Single-code command
    issue("single", 4'd6, 4'd0, 1'b0);
    beat("single0", 4'd5, 1'b1);
    finish_seq("single");

    // Reset after the second beat of an 8-code sequence
    issue("abort", 4'd0, 4'd7, 1'b0);
    beat("abort0", 4'd0, 1'b0);
    beat("abort1", 4'd1, 1'b0);
    reset = 1'b1;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    step();
    chk("abort_done_hold", 32'(done), 32'd0);
    reset = 1'b0;
    step();
    chk("abort_rel_done", 32'(done), 32'd0);
    chk("abort_rel_valid", 32'(out_valid), 32'd0);
    chk("abort_rel_cmd_ready", 32'(cmd_ready), 32'd1);
    issue("restart", 4'd3, 4'd1, 1'b0);
    beat("restart0", 4'd2, 1'b0);
    beat("restart1", 4'd6, 1'b1);
    finish_seq("restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_sequence_controller.md
# gray_sequence_controller

Sequencer that drives the team's binary-to-Gray conversion datapath. It accepts a command of start value, length and direction, and steps an internal binary counter. Each step is emitted as a Gray-coded word on a valid/ready output stream with a last-beat marker, followed by a done pulse. It sits between a control master, such as a test/pattern engine, and any consumer of Gray sequences, such as encoders or CDC pointers.

## Interface
- WIDTH, 4, code width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_start  input  WIDTH  first binary value
- cmd_len  input  WIDTH  number of codes minus one (0 → 1 code)
- cmd_down  input  1  1 = count down, 0 = count up
- out_valid  output  1  out_gray valid
- out_ready  input  1  consumer accepts beat
- out_gray  output  WIDTH  Gray code of current binary count
- out_last  output  1  current beat is final of sequence
- busy  output  1  sequence in progress (RUN or DONE)
- done  output  1  one-cycle pulse after last beat accepted

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1, out_valid=0.
  - On cmd_valid&&cmd_ready: load bin←cmd_start, rem←cmd_len, dir←cmd_down; go to RUN.
- RUN:
  - cmd_ready=0; cmd_valid is ignored and no command is queued.
  - out_valid=1, out_gray=bin^(bin>>1), out_last=(rem==0).
- Beat accepted (out_valid&&out_ready):
  - If rem≠0: bin←bin±1 modulo 2^WIDTH and rem←rem−1.
  - If rem==0: go to DONE.
- No beat accepted: bin, rem, out_gray and out_last are held stable (AXI-style: valid never drops without acceptance).
- Wrap-around: 2^WIDTH−1+1→0 and 0−1→2^WIDTH−1. No error is raised.
- cmd_len=2^WIDTH−1 emits every code once. The final code is adjacent to the first.
- DONE: done=1, busy=1, out_valid=0, cmd_ready=0 for exactly one cycle, then IDLE.
- Reset value of all outputs is 0 except cmd_ready=1, which is combinational from state IDLE. Internal registers reset to 0 and the state resets to IDLE.
- Reset asserted mid-sequence aborts immediately:
  - No done pulse.
  - Partial sequence is discarded.
  - First cycle after reset deassertion is IDLE.

## Timing
- Command handshake in cycle N → first out_valid in cycle N+1.
- Sustained out_ready=1: one code per cycle, so a sequence of L=cmd_len+1 codes occupies cycles N+1…N+L.
- Done pulse occurs in the cycle after the last-beat handshake. Next cmd_ready=1 is one cycle later (minimum 2 idle cycles between sequences' beats).
- out_gray, out_last and out_valid are driven from registers or from state-only decode. There is no combinational path from out_ready or cmd_* to any output.

## Configuration
- GRAY_DOWN_EN defined:
  - cmd_down is honoured.
  - Down-counting is enabled, with wrap at 0→2^WIDTH−1.
- GRAY_DOWN_EN undefined:
  - cmd_down port is still present but ignored, and dir is tied to 0.
  - Counter logic is increment-only.
  - All other behaviour is identical.

## Structure
- Package gray_seq_pkg:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
  - A bin-to-Gray function for bench reference models.
- Sub-module bin_to_gray (combinational, parameterised WIDTH) is instantiated on the registered bin to produce out_gray. It is the only sub-module.

## Test plan
- Up count: WIDTH=4, start=0, len=3, down=0, out_ready=1 → out_gray 0,1,3,2 in consecutive cycles; out_last on 2; done one cycle later; cmd_ready one cycle after that.
- Up wrap: start=14, len=3, down=0 → gray 9,8,0,1; no stall or error at wrap.
- Down count (GRAY_DOWN_EN): start=1, len=2, down=1 → gray 1,0,8. Same command without macro → gray 1,3,2.
- Backpressure: start=5, len=2, with out_ready toggled 0,0,1,0,1,1 → each of gray 7,5,4 is held stable while stalled and advances only on handshake; exactly 3 beats are emitted.
- Command during RUN and single-code command:
  - A second cmd_valid during RUN is not accepted (cmd_ready=0) and causes no sequence corruption.
  - len=0, start=6 → single beat gray 5 with out_last=1.
- Reset mid-run: assert reset after 2nd beat of len=7 sequence → out_valid=0, done never pulses, cmd_ready=1 after release; a new command starts cleanly from its cmd_start.
